// File: rtl/scan_capture_pkg.sv
// Shared constants and FSM state type for the scan_capture display-digit recovery block.
package scan_capture_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 6;
  localparam int IDX_W      = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

endpackage

// File: rtl/scan_capture_onehot_idx.sv
// Combinational decode of the digit enable into an index plus exactly-one / two-or-more flags.
module onehot_idx
  import scan_capture_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] ein,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid,
  output logic                  multi
);

  logic [IDX_W-1:0] ones;

  always_comb begin
    idx  = '0;
    ones = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ein[k]) begin
        idx  = IDX_W'(k);
        ones = ones + IDX_W'(1);
      end
    end
    valid = (ones == IDX_W'(1));
    multi = (ones > IDX_W'(1));
  end

endmodule

// File: rtl/scan_capture.sv
// Rebuilds six digit values from a multiplexed display bus and publishes them as complete frames.
// Optional scan-order checking is enabled by defining SCAN_ORDER_CHECK_EN.
module scan_capture
  import scan_capture_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGIT_W-1:0]    din,
  input  logic [NUM_DIGITS-1:0] ein,
  output logic [DIGIT_W-1:0]    q0,
  output logic [DIGIT_W-1:0]    q1,
  output logic [DIGIT_W-1:0]    q2,
  output logic [DIGIT_W-1:0]    q3,
  output logic [DIGIT_W-1:0]    q4,
  output logic [DIGIT_W-1:0]    q5,
  output logic                  frame_valid,
  output logic                  onehot_err,
  output logic                  order_err
);

  localparam logic [CNT_W-1:0]      HOLD_CNT = CNT_W'(HOLD);
  localparam logic [NUM_DIGITS-1:0] FULL     = '1;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [NUM_DIGITS-1:0]   prev_ein;
  logic [NUM_DIGITS-1:0]   mask, mask_n;
  logic [DIGIT_W-1:0]      shadow [NUM_DIGITS];
  logic [DIGIT_W-1:0]      qbank  [NUM_DIGITS];
  logic [IDX_W-1:0]        idx;
  logic                    valid, multi;
  logic                    cap, wr, frame_done;
  logic                    frame_valid_r, onehot_err_r;

  onehot_idx u_onehot_idx (
    .ein   (ein),
    .idx   (idx),
    .valid (valid),
    .multi (multi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_ein <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      prev_ein <= ein;
    end
  end

  // A digit is captured once per stable enable run, on the edge its run length reaches HOLD.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (multi || !valid) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE:    cnt_n = CNT_W'(1);
        SETTLE:  cnt_n = (ein == prev_ein) ? cnt + CNT_W'(1) : CNT_W'(1);
        default: cnt_n = (ein == prev_ein) ? cnt : CNT_W'(1);
      endcase
      if (state == HELD && ein == prev_ein) begin
        state_n = HELD;
      end else if (cnt_n == HOLD_CNT) begin
        cap     = 1'b1;
        state_n = HELD;
      end else begin
        state_n = SETTLE;
      end
    end
  end

`ifdef SCAN_ORDER_CHECK_EN
  logic [IDX_W-1:0] exp_idx, exp_idx_n;
  logic             order_err_r, order_err_n;

  // An out-of-order digit aborts the frame; digit 0 is allowed to restart it immediately.
  always_comb begin
    wr          = cap;
    mask_n      = mask;
    exp_idx_n   = exp_idx;
    order_err_n = 1'b0;
    if (cap) begin
      if (idx == exp_idx) begin
        exp_idx_n = (exp_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : exp_idx + IDX_W'(1);
      end else begin
        order_err_n = 1'b1;
        mask_n      = '0;
        wr          = (idx == '0);
        exp_idx_n   = (idx == '0) ? IDX_W'(1) : '0;
      end
    end
    if (wr) mask_n = mask_n | ein;
    frame_done = wr && (mask_n == FULL);
    if (frame_done) mask_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_idx     <= '0;
      order_err_r <= 1'b0;
    end else begin
      exp_idx     <= exp_idx_n;
      order_err_r <= order_err_n;
    end
  end

  assign order_err = order_err_r;
`else
  always_comb begin
    wr     = cap;
    mask_n = mask;
    if (wr) mask_n = mask_n | ein;
    frame_done = wr && (mask_n == FULL);
    if (frame_done) mask_n = '0;
  end

  assign order_err = 1'b0;
`endif

  // The output bank takes the shadow copy plus the digit landing on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask          <= '0;
      frame_valid_r <= 1'b0;
      onehot_err_r  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow[k] <= '0;
        qbank[k]  <= '0;
      end
    end else begin
      mask          <= mask_n;
      frame_valid_r <= frame_done;
      if (multi) onehot_err_r <= 1'b1;
      if (wr) shadow[idx] <= din;
      if (frame_done) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          qbank[k] <= (idx == IDX_W'(k)) ? din : shadow[k];
        end
      end
    end
  end

  assign q0          = qbank[0];
  assign q1          = qbank[1];
  assign q2          = qbank[2];
  assign q3          = qbank[3];
  assign q4          = qbank[4];
  assign q5          = qbank[5];
  assign frame_valid = frame_valid_r;
  assign onehot_err  = onehot_err_r;

endmodule

// File: tb/tb_scan_capture.sv
// Randomised and directed bench for scan_capture against a run-length/frame-set reference model.
module tb_scan_capture;

  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] din = '0;
  logic [5:0] ein = '0;
  logic [5:0] q0, q1, q2, q3, q4, q5;
  logic       frame_valid, onehot_err, order_err;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_seen  = 0;

  logic [5:0] m_shadow [6];
  logic [5:0] m_q      [6];
  logic [5:0] m_got;
  logic [5:0] last_e;
  int         run_len;
  int         m_exp;
  bit         m_fv, m_oh, m_oe;

  scan_capture #(.HOLD(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .ein         (ein),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .q4          (q4),
    .q5          (q5),
    .frame_valid (frame_valid),
    .onehot_err  (onehot_err),
    .order_err   (order_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [35:0] modelBank();
    logic [35:0] b;
    b = '0;
    for (int k = 0; k < 6; k++) b[k*6 +: 6] = m_q[k];
    return b;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 6; k++) begin
      m_shadow[k] = '0;
      m_q[k]      = '0;
    end
    m_got   = '0;
    last_e  = '0;
    run_len = 0;
    m_exp   = 0;
    m_fv    = 0;
    m_oh    = 0;
    m_oe    = 0;
  endtask

  // A digit is taken exactly when its enable has been the same one-hot value for HOLD edges.
  task automatic modelEdge(input logic [5:0] e, input logic [5:0] d);
    int  i;
    bit  take;
    m_fv = 0;
    m_oe = 0;
    if ($countones(e) >= 2) begin
      m_oh    = 1;
      run_len = 0;
    end else if (e == 0) begin
      run_len = 0;
    end else if (e == last_e) begin
      run_len++;
    end else begin
      run_len = 1;
    end
    last_e = e;
    if ($countones(e) == 1 && run_len == HOLD) begin
      i = 0;
      for (int k = 0; k < 6; k++) if (e[k]) i = k;
      take = 1;
`ifdef SCAN_ORDER_CHECK_EN
      if (i != m_exp) begin
        m_oe  = 1;
        m_got = '0;
        take  = (i == 0);
        m_exp = (i == 0) ? 1 : 0;
      end else begin
        m_exp = (m_exp + 1) % 6;
      end
`endif
      if (take) begin
        m_shadow[i] = d;
        m_got[i]    = 1'b1;
        if (m_got == 6'b111111) begin
          for (int k = 0; k < 6; k++) m_q[k] = m_shadow[k];
          m_got = '0;
          m_fv  = 1;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("qbank", {28'd0, q5, q4, q3, q2, q1, q0}, {28'd0, modelBank()});
    checkOutput("frame_valid", {63'd0, frame_valid}, {63'd0, m_fv});
    checkOutput("onehot_err", {63'd0, onehot_err}, {63'd0, m_oh});
    checkOutput("order_err", {63'd0, order_err}, {63'd0, m_oe});
  endtask

  task automatic applyStimulus(input logic [5:0] e, input logic [5:0] d);
    @(negedge clk);
    ein = e;
    din = d;
    @(posedge clk);
    modelEdge(e, d);
    #1;
    if (frame_valid) fv_seen++;
    checkAll();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    ein = '0;
    din = '0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic holdDigit(input int k, input int cycles, input logic [5:0] d);
    repeat (cycles) applyStimulus(6'(1 << k), d);
  endtask

  task automatic fullScan(input int cycles);
    for (int k = 0; k < 6; k++) holdDigit(k, cycles, 6'($urandom_range(0, 63)));
  endtask

  initial begin
    logic [5:0]  vals [6];
    logic [35:0] bank_exp;
    int          fv0, cur, mode, a, b;

    modelReset();
    applyReset();

    $display("[TB] scan of six digits with fixed values");
    vals = '{6'b000010, 6'b000000, 6'b000001, 6'b000000, 6'b000001, 6'b000000};
    fv0 = fv_seen;
    for (int k = 0; k < 6; k++) holdDigit(k, 4, vals[k]);
    bank_exp = 36'b000000_000001_000000_000001_000000_000010;
    checkOutput("scan_bank", {28'd0, q5, q4, q3, q2, q1, q0}, {28'd0, bank_exp});
    checkOutput("scan_fv_count", 64'(fv_seen - fv0), 64'd1);
    applyStimulus(6'b000000, 6'd0);

    $display("[TB] short enable blip");
    fv0 = fv_seen;
    applyStimulus(6'b000100, 6'h3f);
    applyStimulus(6'b000000, 6'd0);
    applyStimulus(6'b000000, 6'd0);
    checkOutput("blip_fv_count", 64'(fv_seen - fv0), 64'd0);

    $display("[TB] multi-bit enable");
    repeat (3) applyStimulus(6'b000011, 6'h2a);
    checkOutput("multi_sticky", {63'd0, onehot_err}, 64'd1);
    checkOutput("multi_q_kept", {28'd0, q5, q4, q3, q2, q1, q0}, {28'd0, bank_exp});
    fv0 = fv_seen;
    fullScan(3);
    checkOutput("multi_then_frame", 64'(fv_seen - fv0), 64'd1);
    checkOutput("multi_still_set", {63'd0, onehot_err}, 64'd1);

`ifndef SCAN_ORDER_CHECK_EN
    $display("[TB] digit 2 recaptured within one frame");
    holdDigit(0, 3, 6'd7);
    holdDigit(1, 3, 6'd9);
    holdDigit(2, 3, 6'b000001);
    applyStimulus(6'b000000, 6'd0);
    holdDigit(2, 3, 6'b000101);
    holdDigit(3, 3, 6'd11);
    holdDigit(4, 3, 6'd13);
    holdDigit(5, 3, 6'd15);
    checkOutput("recapture_q2", {58'd0, q2}, 64'b000101);
`else
    $display("[TB] out-of-order scan");
    holdDigit(0, 3, 6'd1);
    holdDigit(1, 3, 6'd2);
    fv0 = fv_seen;
    holdDigit(3, 3, 6'd3);
    checkOutput("order_no_fv", 64'(fv_seen - fv0), 64'd0);
    fullScan(3);
    checkOutput("order_clean_fv", 64'(fv_seen - fv0), 64'd1);
`endif

    $display("[TB] reset in the middle of a frame");
    holdDigit(0, 3, 6'd21);
    holdDigit(1, 3, 6'd22);
    holdDigit(2, 3, 6'd23);
    applyReset();
    checkOutput("reset_bank", {28'd0, q5, q4, q3, q2, q1, q0}, 64'd0);
    fv0 = fv_seen;
    fullScan(2);
    checkOutput("reset_then_frame", 64'(fv_seen - fv0), 64'd1);

    $display("[TB] random scanning");
    cur = 5;
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 99);
      if (mode < 70) begin
        cur = (cur + 1) % 6;
        holdDigit(cur, $urandom_range(1, 4), 6'($urandom_range(0, 63)));
      end else if (mode < 85) begin
        holdDigit($urandom_range(0, 5), $urandom_range(1, 4), 6'($urandom_range(0, 63)));
      end else if (mode < 93) begin
        repeat ($urandom_range(1, 2)) applyStimulus(6'b000000, 6'($urandom_range(0, 63)));
      end else begin
        a = $urandom_range(0, 5);
        b = (a + $urandom_range(1, 5)) % 6;
        applyStimulus(6'((1 << a) | (1 << b)), 6'($urandom_range(0, 63)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
